// File: rtl/alu_issue.sv
// Issue stage in front of the ALU: decodes instructions, reads operands, tracks busy registers.
// Optional same-cycle writeback forwarding is enabled by defining ISSUE_WB_BYPASS_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module alu_issue #(
    parameter int REG_CNT = 8,
    parameter int DW      = `DATA_WIDTH,
    parameter int AW      = $clog2(REG_CNT),
    parameter int IW      = 3 + 3 * AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_op,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [AW-1:0] out_dst,
    output logic          out_wr,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);

    typedef logic [DW-1:0] t_data;

    typedef enum logic [2:0] {
        OP_LD   = 3'd0,
        OP_OUT  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XOR  = 3'd6,
        OP_SHFL = 3'd7
    } t_opcode;

    t_data            rf [REG_CNT];
    logic [REG_CNT-1:0] busy;
    logic [REG_CNT-1:0] busy_nxt;

    // Stage p0: decode and operand read, combinational from in_instr
    t_opcode          op_p0;
    logic [AW-1:0]    dst_p0;
    logic [AW-1:0]    src_a_p0;
    logic [AW-1:0]    src_b_p0;
    logic [2*AW-1:0]  imm_p0;
    logic             uses_src_p0;
    logic             wr_p0;
    t_data            rd_a_p0;
    t_data            rd_b_p0;
    logic             busy_a_p0;
    logic             busy_b_p0;
    t_data            a_p0;
    t_data            b_p0;
    logic             stall_p0;
    logic             load_p0;
    logic             fire_p0;

    assign op_p0       = t_opcode'(in_instr[IW-1 -: 3]);
    assign dst_p0      = in_instr[3*AW-1 -: AW];
    assign src_a_p0    = in_instr[2*AW-1 -: AW];
    assign src_b_p0    = in_instr[AW-1:0];
    assign imm_p0      = {src_a_p0, src_b_p0};
    assign uses_src_p0 = (op_p0 != OP_LD);
    assign wr_p0       = (op_p0 != OP_OUT);

`ifdef ISSUE_WB_BYPASS_EN
    logic byp_a_p0;
    logic byp_b_p0;

    // A source being written back this cycle is taken straight from wb_data
    assign byp_a_p0  = wb_we && (wb_addr == src_a_p0);
    assign byp_b_p0  = wb_we && (wb_addr == src_b_p0);
    assign rd_a_p0   = byp_a_p0 ? wb_data : rf[src_a_p0];
    assign rd_b_p0   = byp_b_p0 ? wb_data : rf[src_b_p0];
    assign busy_a_p0 = busy[src_a_p0] && !byp_a_p0;
    assign busy_b_p0 = busy[src_b_p0] && !byp_b_p0;
`else
    assign rd_a_p0   = rf[src_a_p0];
    assign rd_b_p0   = rf[src_b_p0];
    assign busy_a_p0 = busy[src_a_p0];
    assign busy_b_p0 = busy[src_b_p0];
`endif

    assign a_p0 = uses_src_p0 ? rd_a_p0 : t_data'(imm_p0);
    assign b_p0 = uses_src_p0 ? rd_b_p0 : '0;

    assign stall_p0 = (uses_src_p0 && (busy_a_p0 || busy_b_p0)) || (wr_p0 && busy[dst_p0]);

    // Stage p1: registered issue toward the ALU
    logic             vld_p1;
    t_opcode          op_p1;
    t_data            a_p1;
    t_data            b_p1;
    logic [AW-1:0]    dst_p1;
    logic             wr_p1;

    assign load_p0  = !vld_p1 || out_ready;
    assign in_ready = rst_n && !stall_p0 && load_p0;
    assign fire_p0  = in_valid && in_ready;

    // Clear before set so a same-cycle issue to a written-back register stays busy
    always_comb begin
        busy_nxt = busy;
        if (wb_we) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (fire_p0 && wr_p0) begin
            busy_nxt[dst_p0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            op_p1  <= OP_LD;
            a_p1   <= '0;
            b_p1   <= '0;
            dst_p1 <= '0;
            wr_p1  <= 1'b0;
            busy   <= '0;
            for (int i = 0; i < REG_CNT; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (load_p0) begin
                vld_p1 <= fire_p0;
                if (fire_p0) begin
                    op_p1  <= op_p0;
                    a_p1   <= a_p0;
                    b_p1   <= b_p0;
                    dst_p1 <= dst_p0;
                    wr_p1  <= wr_p0;
                end
            end
            busy <= busy_nxt;
            if (wb_we) begin
                rf[wb_addr] <= wb_data;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_op    = op_p1;
    assign out_a     = a_p1;
    assign out_b     = b_p1;
    assign out_dst   = dst_p1;
    assign out_wr    = wr_p1;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue (default build, no writeback bypass): directed scenarios followed by
// randomized traffic against a register/busy-bit reference model with a bench-side ALU.
module tb_alu_issue;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [11:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_op;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [AW-1:0] out_dst;
    logic          out_wr;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    always #5 clk = ~clk;

    alu_issue #(.REG_CNT(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_a(out_a), .out_b(out_b), .out_dst(out_dst), .out_wr(out_wr),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: register contents, busy flags, and the expected issue slot
    logic [7:0] m_rf [N];
    bit         m_busy [N];
    bit         m_vld;
    logic [2:0] m_op;
    logic [7:0] m_a, m_b;
    logic [2:0] m_dst;
    bit         m_wr;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } wb_t;
    wb_t wbq[$];
    bit  alu_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk(input int op, input int d, input int a, input int b);
        return {3'(op), 3'(d), 3'(a), 3'(b)};
    endfunction

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return a ^ b;
            3'd7:    return {a[3:0], a[7:4]};
            default: return a;
        endcase
    endfunction

    // Check the current cycle against the model, advance the model past the edge, land on negedge
    task automatic step(input string tag);
        logic [2:0] op, d, sa, sb;
        logic [7:0] a, b;
        bit uses, wr, rdy, fire, load;
        wb_t e;
        #1;
        op = in_instr[11:9];
        d  = in_instr[8:6];
        sa = in_instr[5:3];
        sb = in_instr[2:0];
        uses = (op != 3'd0);
        wr   = (op != 3'd1);
        rdy  = rst_n && !((uses && (m_busy[sa] || m_busy[sb])) || (wr && m_busy[d]))
               && (!m_vld || out_ready);
        chk({tag, " in_ready"}, in_ready, rdy);
        chk({tag, " out_valid"}, out_valid, m_vld);
        if (m_vld) begin
            chk({tag, " out_op"}, out_op, m_op);
            chk({tag, " out_a"}, out_a, m_a);
            chk({tag, " out_b"}, out_b, m_b);
            chk({tag, " out_dst"}, out_dst, m_dst);
            chk({tag, " out_wr"}, out_wr, m_wr);
        end
        if (!rst_n) begin
            m_vld = 0; m_op = 0; m_a = 0; m_b = 0; m_dst = 0; m_wr = 0;
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0;
                m_rf[i]   = 8'h00;
            end
        end else begin
            if (alu_en && m_vld && out_ready && m_wr) begin
                e.addr = m_dst;
                e.data = alu(m_op, m_a, m_b);
                wbq.push_back(e);
            end
            fire = in_valid && rdy;
            load = !m_vld || out_ready;
            a = uses ? m_rf[sa] : {2'b00, sa, sb};
            b = uses ? m_rf[sb] : 8'h00;
            if (load) begin
                m_vld = fire;
                if (fire) begin
                    m_op = op; m_a = a; m_b = b; m_dst = d; m_wr = wr;
                end
            end
            if (wb_we) m_busy[wb_addr] = 0;
            if (fire && wr) m_busy[d] = 1;
            if (wb_we) m_rf[wb_addr] = wb_data;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_instr = mk(0, 1, 5, 2); out_ready = 1'b1;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        m_vld = 0;
        @(negedge clk);

        // Reset held two cycles with a valid instruction presented
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_op", out_op, 0);
        chk("rst out_a", out_a, 0);
        chk("rst out_b", out_b, 0);
        chk("rst out_dst", out_dst, 0);
        chk("rst out_wr", out_wr, 0);
        step("rst0");
        step("rst1");
        rst_n = 1'b1; in_valid = 1'b0;
        #1; chk("idle in_ready", in_ready, 1);
        step("idle");

        // LD r1,#0x2A then dependent ADD r3,r1,r2 waits for writeback
        in_valid = 1'b1; in_instr = mk(0, 1, 5, 2);
        step("ld1");
        in_instr = mk(2, 3, 1, 2);
        #1;
        chk("ld out_valid", out_valid, 1);
        chk("ld out_op", out_op, 0);
        chk("ld out_a", out_a, 8'h2A);
        chk("ld out_b", out_b, 0);
        chk("ld out_dst", out_dst, 1);
        chk("ld out_wr", out_wr, 1);
        chk("raw stall0", in_ready, 0);
        step("raw0");
        #1; chk("raw stall1", in_ready, 0);
        step("raw1");
        wb_we = 1'b1; wb_addr = 3'd1; wb_data = 8'h2A;
        #1; chk("raw stall wb cycle", in_ready, 0);
        step("raw_wb");
        wb_we = 1'b0;
        #1; chk("raw release", in_ready, 1);
        step("add_issue");
        in_valid = 1'b0;
        #1;
        chk("add out_op", out_op, 2);
        chk("add out_a", out_a, 8'h2A);
        chk("add out_b", out_b, 0);
        chk("add out_dst", out_dst, 3);
        step("add_out");
        wb_we = 1'b1; wb_addr = 3'd3; wb_data = 8'h2A;
        step("wb3");
        wb_we = 1'b0;

        // Output backpressure holds the issue slot and blocks input
        in_valid = 1'b1; in_instr = mk(0, 5, 2, 1);
        step("ld5");
        out_ready = 1'b0; in_instr = mk(0, 6, 0, 7);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold out_valid", out_valid, 1);
            chk("hold out_a", out_a, 8'h11);
            chk("hold out_dst", out_dst, 5);
            chk("hold in_ready", in_ready, 0);
            step("hold");
        end
        out_ready = 1'b1;
        #1; chk("release in_ready", in_ready, 1);
        step("ld6");
        #1;
        chk("ld6 out_a", out_a, 8'h07);
        chk("ld6 out_dst", out_dst, 6);

        // Issue setting busy[4] in the same cycle as a writeback to r4: busy stays set
        in_instr = mk(0, 4, 7, 4);
        wb_we = 1'b1; wb_addr = 3'd4; wb_data = 8'h99;
        #1; chk("setclr in_ready", in_ready, 1);
        step("setclr");
        wb_we = 1'b0; in_instr = mk(2, 0, 4, 0);
        #1;
        chk("setwins stall", in_ready, 0);
        chk("ld4 out_a", out_a, 8'h3C);
        step("setwins");
        wb_we = 1'b1; wb_addr = 3'd4; wb_data = 8'h3C;
        step("wb4");
        wb_we = 1'b0;
        #1; chk("r4 release", in_ready, 1);
        step("add_r4");
        #1;
        chk("add_r4 out_a", out_a, 8'h3C);
        chk("add_r4 out_b", out_b, 8'h00);

        // OUT writes nothing and leaves busy[dst] untouched
        in_instr = mk(1, 1, 1, 1);
        step("out1");
        in_instr = mk(2, 2, 1, 1);
        #1;
        chk("out out_op", out_op, 1);
        chk("out out_wr", out_wr, 0);
        chk("out out_a", out_a, 8'h2A);
        chk("out out_b", out_b, 8'h2A);
        chk("out no busy", in_ready, 1);
        step("add_r2");

        // Reset with r2 busy and an issue pending; late writeback afterwards
        out_ready = 1'b0; in_valid = 1'b0;
        #1; chk("pre-rst out_valid", out_valid, 1);
        step("pre_rst");
        rst_n = 1'b0;
        step("mid_rst");
        rst_n = 1'b1; in_instr = mk(2, 3, 2, 2);
        #1;
        chk("post-rst out_valid", out_valid, 0);
        chk("post-rst busy clear", in_ready, 1);
        step("post_rst");
        wb_we = 1'b1; wb_addr = 3'd2; wb_data = 8'h55;
        step("late_wb");
        wb_we = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_instr = mk(1, 0, 2, 2);
        #1; chk("late in_ready", in_ready, 1);
        step("out_r2");
        in_valid = 1'b0;
        #1;
        chk("late out_a", out_a, 8'h55);
        chk("late out_b", out_b, 8'h55);
        step("drain");

        // Randomized traffic; the bench acts as the ALU returning results out of a queue
        alu_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = 12'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
                wb_we   = 1'b1;
                wb_addr = wbq[0].addr;
                wb_data = wbq[0].data;
                void'(wbq.pop_front());
            end else begin
                wb_we   = ($urandom_range(0, 29) == 0);
                wb_addr = 3'($urandom);
                wb_data = 8'($urandom);
            end
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
